// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: hazard controller for the 5-stage RV32 pipeline.
// Produces EX-stage forward selects, load-use stalls, branch flushes and a
// data-memory wait handshake with an optional timeout abort.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush/forward
// event counters (StallCnt, FlushCnt, FwdCnt).
module hazard_ctrl_unit #(
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] Rs1_D,
    input  logic [REG_AW-1:0] Rs2_D,
    input  logic [REG_AW-1:0] Rs1_E,
    input  logic [REG_AW-1:0] Rs2_E,
    input  logic [REG_AW-1:0] RD_E,
    input  logic [REG_AW-1:0] RD_M,
    input  logic [REG_AW-1:0] RD_W,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE,
    input  logic              PCSrcE,
    input  logic              MemReqM,
    input  logic              MemReadyM,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              StallM,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushW,
    output logic              MemErr,
    output logic              MemBusy
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0]  StallCnt,
    output logic [CNT_W-1:0]  FlushCnt,
    output logic [CNT_W-1:0]  FwdCnt
`endif
);

    // Wait counter only needs to reach TIMEOUT-1.
    localparam int TW   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_e;

    state_e        state_q;
    logic [TW-1:0] cnt_q;
    logic          mem_err_q;

    logic          abort;
    logic          mem_stall;
    logic          lw_stall;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;

    // Memory stage result wins over writeback; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_m,
        input logic              we_w
    );
        if (we_m && (rd_m != '0) && (rd_m == rs))
            return 2'b10;
        else if (we_w && (rd_w != '0) && (rd_w == rs))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign fwd_a = fwd_sel(Rs1_E, RD_M, RD_W, RegWriteM, RegWriteW);
    assign fwd_b = fwd_sel(Rs2_E, RD_M, RD_W, RegWriteM, RegWriteW);

    assign abort     = (TIMEOUT != 0) && (state_q == S_WAIT) && (cnt_q == TW'(TLIM));
    assign mem_stall = MemReqM && !MemReadyM && !abort;
    assign lw_stall  = ResultSrcE && (RD_E != '0) && ((RD_E == Rs1_D) || (RD_E == Rs2_D));

    // Prioritised stall/flush decode; everything held low while in reset.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        if (rst) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            if (mem_stall) begin
                // Freeze the whole front; a branch in E re-resolves once released.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (PCSrcE) begin
                // Squashing D also kills any load-use dependency there.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (lw_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // Memory-wait FSM: counts WAIT cycles and aborts with a sticky error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (mem_stall) begin
                        state_q <= S_WAIT;
                        cnt_q   <= '0;
                    end
                end
                S_WAIT: begin
                    if (MemReadyM) begin
                        // Ready on the timeout cycle still counts as success.
                        state_q <= S_IDLE;
                    end else if (abort) begin
                        state_q   <= S_IDLE;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + TW'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign MemBusy = (state_q == S_WAIT);
    assign MemErr  = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic [CNT_W-1:0] fwd_cnt_q;

    // Saturating event counters sampled from the final decoded controls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            if (StallF && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (FlushE && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
            if (((ForwardAE != 2'b00) || (ForwardBE != 2'b00)) && (fwd_cnt_q != '1))
                fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
    assign FwdCnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Self-checking bench for hazard_ctrl_unit (TIMEOUT=4, CNT_W=4).
module tb_hazard_ctrl_unit;

    localparam int AW = 5;
    localparam int TO = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, RD_E, RD_M, RD_W;
    logic          RegWriteM, RegWriteW, ResultSrcE, PCSrcE, MemReqM, MemReadyM;
    logic [1:0]    ForwardAE, ForwardBE;
    logic          StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemErr, MemBusy;
`ifdef HAZARD_PERF_EN
    logic [CW-1:0] StallCnt, FlushCnt, FwdCnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    hazard_ctrl_unit #(.REG_AW(AW), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rs1_E(Rs1_E), .Rs2_E(Rs2_E),
        .RD_E(RD_E), .RD_M(RD_M), .RD_W(RD_W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .ResultSrcE(ResultSrcE),
        .PCSrcE(PCSrcE), .MemReqM(MemReqM), .MemReadyM(MemReadyM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .MemErr(MemErr), .MemBusy(MemBusy)
`ifdef HAZARD_PERF_EN
        , .StallCnt(StallCnt), .FlushCnt(FlushCnt), .FwdCnt(FwdCnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_wait;      // a memory access is being waited on
    int m_n;         // completed WAIT cycles in current wait
    bit m_err;
    int m_sc, m_fc, m_wc;

    function automatic int mfwd(input int rs);
        if (RegWriteM && RD_M != 0 && int'(RD_M) == rs) return 2;
        if (RegWriteW && RD_W != 0 && int'(RD_W) == rs) return 1;
        return 0;
    endfunction

    always @(negedge clk) begin
        int ea, eb;
        bit ab, ms, lw, es, efd, efe, efw;
        ea = 0; eb = 0; ab = 0; ms = 0; lw = 0; es = 0; efd = 0; efe = 0; efw = 0;
        if (!rst) begin
            m_wait = 0; m_n = 0; m_err = 0; m_sc = 0; m_fc = 0; m_wc = 0;
        end else begin
            ea = mfwd(int'(Rs1_E));
            eb = mfwd(int'(Rs2_E));
            ab = m_wait && (m_n == TO - 1);
            ms = MemReqM && !MemReadyM && !ab;
            lw = ResultSrcE && RD_E != 0 && (RD_E == Rs1_D || RD_E == Rs2_D);
            if (ms) begin es = 1; efw = 1; end
            else if (PCSrcE) begin efd = 1; efe = 1; end
            else if (lw) begin es = 1; efe = 1; end
        end
        chk("m_fae", ForwardAE, ea);
        chk("m_fbe", ForwardBE, eb);
        chk("m_stallf", StallF, es);
        chk("m_stalld", StallD, es);
        chk("m_stalle", StallE, ms);
        chk("m_stallm", StallM, ms);
        chk("m_flushd", FlushD, efd);
        chk("m_flushe", FlushE, efe);
        chk("m_flushw", FlushW, efw);
        chk("m_busy", MemBusy, m_wait);
        chk("m_err", MemErr, m_err);
`ifdef HAZARD_PERF_EN
        chk("m_stallcnt", StallCnt, m_sc);
        chk("m_flushcnt", FlushCnt, m_fc);
        chk("m_fwdcnt", FwdCnt, m_wc);
`endif
        if (rst) begin
            if (es && m_sc < CMAX) m_sc++;
            if (efe && m_fc < CMAX) m_fc++;
            if ((ea != 0 || eb != 0) && m_wc < CMAX) m_wc++;
            if (!m_wait) begin
                if (ms) begin m_wait = 1; m_n = 0; end
            end else if (MemReadyM) m_wait = 0;
            else if (ab) begin m_wait = 0; m_err = 1; end
            else m_n++;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic idle_in();
        Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0; RD_E = 0; RD_M = 0; RD_W = 0;
        RegWriteM = 0; RegWriteW = 0; ResultSrcE = 0; PCSrcE = 0; MemReqM = 0; MemReadyM = 0;
    endtask

    task automatic go();
        @(posedge clk); #1;
    endtask

    task automatic look();
        @(negedge clk); #1;
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        MemReqM = 1; RegWriteM = 1; RD_M = 5; Rs1_E = 5; ResultSrcE = 1; RD_E = 7; Rs1_D = 7;
        look();
        chk("rst_fae", ForwardAE, 0);
        chk("rst_stallf", StallF, 0);
        chk("rst_flushe", FlushE, 0);
        chk("rst_busy", MemBusy, 0);
        go(); rst = 1'b1; idle_in();

        // forwarding priority and x0
        RegWriteM = 1; RD_M = 5; RegWriteW = 1; RD_W = 5; Rs1_E = 5; Rs2_E = 3;
        look(); chk("fwd_m", ForwardAE, 2'b10); chk("fwd_b_none", ForwardBE, 2'b00);
        go(); RegWriteM = 0;
        look(); chk("fwd_w", ForwardAE, 2'b01);
        go(); RegWriteM = 1; RD_M = 0; RD_W = 0; Rs1_E = 0;
        look(); chk("fwd_x0", ForwardAE, 2'b00);
        go(); RD_M = 9; RD_W = 3; Rs1_E = 9; Rs2_E = 3;
        look(); chk("fwd_b_w", ForwardBE, 2'b01); chk("fwd_a_m", ForwardAE, 2'b10);

        // load-use
        go(); idle_in(); ResultSrcE = 1; RD_E = 7; Rs2_D = 7;
        look(); chk("lu_stallf", StallF, 1); chk("lu_stalld", StallD, 1);
        chk("lu_flushe", FlushE, 1); chk("lu_flushd", FlushD, 0); chk("lu_stalle", StallE, 0);
        go(); idle_in();
        look(); chk("lu_after", StallF, 0); chk("lu_after_fe", FlushE, 0);
        go(); ResultSrcE = 1; RD_E = 0;
        look(); chk("lu_x0", StallF, 0);

        // branch beats load-use
        go(); idle_in(); PCSrcE = 1; ResultSrcE = 1; RD_E = 7; Rs1_D = 7;
        look(); chk("br_fd", FlushD, 1); chk("br_fe", FlushE, 1); chk("br_sf", StallF, 0);

        // memory wait, ready after 3 stall cycles
        go(); idle_in(); MemReqM = 1;
        for (int i = 0; i < 3; i++) begin
            look();
            chk("mw_stallf", StallF, 1); chk("mw_stallm", StallM, 1);
            chk("mw_flushw", FlushW, 1); chk("mw_busy", MemBusy, (i > 0) ? 1 : 0);
            go();
        end
        MemReadyM = 1;
        look(); chk("mw_rel", StallF, 0); chk("mw_rel_fw", FlushW, 0); chk("mw_busy3", MemBusy, 1);
        go(); idle_in();
        look(); chk("mw_idle", MemBusy, 0); chk("mw_noerr", MemErr, 0);

        // timeout with branch pending in E
        go(); MemReqM = 1; PCSrcE = 1;
        for (int i = 0; i < 4; i++) begin
            look();
            chk("to_stallf", StallF, 1); chk("to_flushd", FlushD, 0);
            chk("to_flushe", FlushE, 0); chk("to_flushw", FlushW, 1);
            go();
        end
        look(); chk("to_rel", StallF, 0); chk("to_rel_fw", FlushW, 0);
        chk("to_br", FlushD, 1); chk("to_busy", MemBusy, 1); chk("to_err_pre", MemErr, 0);
        go(); idle_in();
        look(); chk("to_err", MemErr, 1); chk("to_idle", MemBusy, 0);
        go(); go(); go();
        look(); chk("to_sticky", MemErr, 1);

        // asynchronous reset while waiting
        go(); MemReqM = 1; RegWriteM = 1; RD_M = 5; Rs1_E = 5;
        look(); chk("ar_stall", StallF, 1);
        go();
        look(); chk("ar_busy", MemBusy, 1);
        go(); rst = 1'b0; #1;
        chk("ar_stallf", StallF, 0); chk("ar_flushw", FlushW, 0); chk("ar_fae", ForwardAE, 0);
        chk("ar_busy0", MemBusy, 0); chk("ar_err0", MemErr, 0);
        go(); rst = 1'b1; idle_in();
        look(); chk("ar_after", MemErr, 0);

        // ready arriving on the timeout cycle wins
        go(); MemReqM = 1;
        for (int i = 0; i < 4; i++) begin
            look(); chk("rt_stall", StallF, 1); go();
        end
        MemReadyM = 1;
        look(); chk("rt_rel", StallF, 0); chk("rt_noerr", MemErr, 0);
        go(); idle_in();
        look(); chk("rt_noerr2", MemErr, 0); chk("rt_idle", MemBusy, 0);

`ifdef HAZARD_PERF_EN
        // counter saturation
        go(); ResultSrcE = 1; RD_E = 7; Rs1_D = 7;
        repeat (20) go();
        look(); chk("pf_stall_sat", StallCnt, CMAX); chk("pf_flush_sat", FlushCnt, CMAX);
`endif

        go(); idle_in();
        look();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
